// File: rtl/if_id_fetch_buffer_if.sv
// Fetch/decode handshake bundle for if_id_fetch_buffer.
// Valid/ready rule: an entry moves only on a rising edge where its valid and the
// receiver's ready are both high; fetch "ready" is PCWriteEnable.
interface if_id_fetch_buffer_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   FetchValid;
    logic [ADDR_WIDTH-1:0]  FetchPC;
    logic [INSTR_WIDTH-1:0] FetchInstruction;
    logic                   PCWriteEnable;
    logic                   Flush;
    logic                   DecodeReady;
    logic                   DecodeValid;
    logic [ADDR_WIDTH-1:0]  DecodePC;
    logic [ADDR_WIDTH-1:0]  DecodePCPlus4;
    logic [INSTR_WIDTH-1:0] DecodeInstruction;

    modport master (
        output FetchValid, FetchPC, FetchInstruction, Flush, DecodeReady,
        input  PCWriteEnable, DecodeValid, DecodePC, DecodePCPlus4, DecodeInstruction
    );

    modport slave (
        input  FetchValid, FetchPC, FetchInstruction, Flush, DecodeReady,
        output PCWriteEnable, DecodeValid, DecodePC, DecodePCPlus4, DecodeInstruction
    );
endinterface

// File: rtl/if_id_fetch_buffer.sv
// IF/ID FIFO holding {PC, instruction} pairs between fetch and decode.
// Define IF_ID_FETCH_STATS_EN to add FetchedCount/FlushedCount statistics outputs.
module if_id_fetch_buffer #(
    parameter int DEPTH       = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                     Clock,
    input  logic                     Reset,
    if_id_fetch_buffer_if.slave      bus,
    output logic [$clog2(DEPTH):0]   Occupancy
`ifdef IF_ID_FETCH_STATS_EN
    ,
    output logic [31:0]              FetchedCount,
    output logic [31:0]              FlushedCount
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   head_valid;
    logic                   push;
    logic                   pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign head_valid = (count != '0);
    assign push       = bus.FetchValid && !full && !bus.Flush;
    assign pop        = head_valid && bus.DecodeReady && !bus.Flush;

    // Depends only on registered fullness and Flush, never on DecodeReady.
    assign bus.PCWriteEnable = !full || bus.Flush;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; count alone decides what is valid.
    always_ff @(posedge Clock) begin
        if (push) begin
            pc_mem[wr_ptr]    <= bus.FetchPC;
            instr_mem[wr_ptr] <= bus.FetchInstruction;
        end
    end

    always_comb begin
        bus.DecodeValid       = head_valid;
        bus.DecodePC          = '0;
        bus.DecodePCPlus4     = '0;
        bus.DecodeInstruction = '0;
        if (head_valid) begin
            bus.DecodePC          = pc_mem[rd_ptr];
            bus.DecodePCPlus4     = pc_mem[rd_ptr] + ADDR_WIDTH'(4);
            bus.DecodeInstruction = instr_mem[rd_ptr];
        end
    end

    assign Occupancy = count;

`ifdef IF_ID_FETCH_STATS_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            FetchedCount <= '0;
            FlushedCount <= '0;
        end else begin
            if (push) FetchedCount <= FetchedCount + 32'd1;
            // A flush drops everything held plus the fetch offered that cycle.
            if (bus.Flush)
                FlushedCount <= FlushedCount + 32'(count) + 32'(bus.FetchValid);
        end
    end
`endif
endmodule

// File: doc/if_id_fetch_buffer.md
Name: if_id_fetch_buffer

Overview:
- Small FIFO between the program counter / instruction memory (fetch) and the decode stage.
- Captures each fetched {PC, instruction} pair and presents it to decode with a valid/ready handshake.
- Drives the PC register's write enable so the PC advances only when the buffer can accept the fetched instruction.
- Flush discards all buffered entries on a branch/jump redirect.

Parameters:
DEPTH, 2, number of buffered entries; power of two, >= 2
ADDR_WIDTH, 32, PC/address width
INSTR_WIDTH, 32, instruction width

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
FetchValid  input  1  fetch stage presents a valid PC/instruction this cycle
FetchPC  input  ADDR_WIDTH  PC of fetched instruction
FetchInstruction  input  INSTR_WIDTH  instruction word read at FetchPC
PCWriteEnable  output  1  connects to the PC register's write enable; 1 = PC may advance
Flush  input  1  redirect: discard buffered and incoming entries
DecodeReady  input  1  decode accepts head entry this cycle
DecodeValid  output  1  head entry valid
DecodePC  output  ADDR_WIDTH  head entry PC
DecodePCPlus4  output  ADDR_WIDTH  head entry PC + 4
DecodeInstruction  output  INSTR_WIDTH  head entry instruction
Occupancy  output  clog2(DEPTH)+1  current entry count

Behaviour:
- Reset (Reset=0, asynchronous): count, read and write pointers = 0; DecodeValid=0; Occupancy=0; PCWriteEnable=1. Storage contents need not be cleared. Release is synchronous to Clock.
- Full = (count == DEPTH). PCWriteEnable = !Full || Flush.
  - Purely from registered state plus Flush; no combinational path from DecodeReady.
- Push: FetchValid && !Full && !Flush at a rising edge. Writes {FetchPC, FetchInstruction} at the write pointer; pointer increments mod DEPTH.
- Pop: DecodeValid && DecodeReady && !Flush at a rising edge. Read pointer increments mod DEPTH.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Push while Full is rejected, even if a pop occurs the same cycle; fetch must re-present because the PC was held.
- Pop while empty is ignored.
- Latency: an entry pushed at edge N is visible with DecodeValid=1 immediately after edge N. There is no same-cycle fetch-to-decode bypass.
- Outputs when DecodeValid=1:
  - DecodePC, DecodeInstruction = head entry.
  - DecodePCPlus4 = DecodePC + 4, truncated to ADDR_WIDTH (0xFFFFFFFC -> 0x00000000).
- Outputs when DecodeValid=0: DecodePC, DecodePCPlus4, DecodeInstruction driven to 0.
- Flush = 1 at an edge:
  - count and both pointers -> 0.
  - The incoming fetch that cycle is discarded.
  - The pop is discarded.
  - DecodeValid=0 after the edge.
  - Flush has priority over push and pop.
- Occupancy = count, registered.

Optional Feature:
- Macro IF_ID_FETCH_STATS_EN.
- Defined: adds outputs FetchedCount[31:0] and FlushedCount[31:0].
  - FetchedCount increments on every accepted push.
  - FlushedCount adds the number of entries discarded by each flush (count at the flush edge, plus 1 if FetchValid was high that cycle).
  - Both counters wrap at 2^32 and reset to 0 on Reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset low mid-stream with 2 entries held -> immediately DecodeValid=0, Occupancy=0, PCWriteEnable=1, outputs 0.
- Push PC=0x00, 0x04 with DecodeReady=0 -> Occupancy=2, PCWriteEnable=0; a third fetch (PC=0x08) is not stored; the DecodeReady=1 pop then yields PC 0x00, PCPlus4 0x04.
- Continuous FetchValid=1, DecodeReady=1 for 10 cycles -> Occupancy stays 1 after the first edge; decode sees PCs 0x00..0x24 in order, with no gaps or duplicates.
- Flush with 2 entries held and FetchValid=1 -> next cycle DecodeValid=0, Occupancy=0, PCWriteEnable=1; the next push (PC=0x40) appears as the head.
- Push FetchPC=0xFFFFFFFC -> DecodePCPlus4=0x00000000.
- With IF_ID_FETCH_STATS_EN: 5 pushes, then a flush with 2 entries held and FetchValid=1 -> FetchedCount=5, FlushedCount=3.
